// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, master IDs and the address-range helper for the data-memory arbiter.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int NEL    = 1024;
  localparam int IDX_W  = $clog2(NEL);

  localparam logic [ADDR_W-1:0] BASE_ADDR = 32'd8192;
  localparam logic [ADDR_W-1:0] END_ADDR  = BASE_ADDR + ADDR_W'(4 * NEL);

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_id_e;

  // Plain unsigned compares: addresses below BASE_ADDR can never wrap into range.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr >= BASE_ADDR) && (addr < END_ADDR) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; input 1 can lock the grant while its lock request stays high.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt
);

  mst_id_e last_gnt_q, last_gnt_d;
  logic    locked_q, locked_d;

  always_comb begin
    gnt        = 2'b00;
    last_gnt_d = last_gnt_q;
    locked_d   = locked_q;

    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (locked_q || (last_gnt_q == MST_M0)) gnt = 2'b10;
          else                                    gnt = 2'b01;
        end
        default: gnt = 2'b00;
      endcase
    end

    if (gnt[0])      last_gnt_d = MST_M0;
    else if (gnt[1]) last_gnt_d = MST_M1;

    // Lock is taken only on an M1 grant but released as soon as M1 drops its lock request.
    if (gnt[1] && lock) locked_d = 1'b1;
    else if (!lock)     locked_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= MST_M1;
      locked_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      locked_q   <= locked_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (M0) and a loader/debug master (M1),
// translating byte addresses to word indices and returning tagged responses one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  output logic              M0_GNT,
  output logic              M0_RVALID,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic              M0_ERR,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic              M1_LOCK,
  output logic              M1_GNT,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic              M1_ERR,
  output logic [IDX_W-1:0]  MEM_ADDR,
  output logic              MEM_WR_EN,
  output logic              MEM_RD_EN,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT
);

  // Handshake: a master holds REQ/WE/ADDR/WDATA until it sees GNT=1 in the same cycle; the
  // transfer completes on that edge and exactly one RVALID follows on the next cycle.
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              acc_ok;
  logic              mem_go;
  logic [IDX_W-1:0]  word_idx;

  logic [IDX_W-1:0]  mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  mst_id_e           rsp_owner_q, rsp_owner_d;
  logic              rsp_rd_q, rsp_rd_d;
  logic              rsp_err_q, rsp_err_d;
  logic              m0_hit, m1_hit;

  rr_arb2 u_arb (
    .clk  (CLK),
    .rst  (RST),
    .req  ({M1_REQ, M0_REQ}),
    .lock (M1_LOCK),
    .gnt  (gnt)
  );

  always_comb begin
    any_gnt   = gnt[0] | gnt[1];
    sel_we    = gnt[1] ? M1_WE    : M0_WE;
    sel_addr  = gnt[1] ? M1_ADDR  : M0_ADDR;
    sel_wdata = gnt[1] ? M1_WDATA : M0_WDATA;
    acc_ok    = addr_in_range(sel_addr);
    mem_go    = any_gnt && acc_ok;
    // BASE_ADDR is word aligned, so subtracting the word-index fields equals (ADDR-BASE)>>2.
    word_idx  = sel_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];

    mem_addr_d  = mem_go ? word_idx : mem_addr_q;
    rsp_valid_d = any_gnt;
    rsp_owner_d = gnt[1] ? MST_M1 : MST_M0;
    rsp_rd_d    = mem_go && !sel_we;
    rsp_err_d   = any_gnt && !acc_ok;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= MST_M0;
      rsp_rd_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    M0_GNT    = gnt[0];
    M1_GNT    = gnt[1];
    MEM_ADDR  = mem_addr_d;
    MEM_WR_EN = mem_go && sel_we;
    MEM_RD_EN = mem_go && !sel_we;
    MEM_DIN   = sel_wdata;

    m0_hit    = rsp_valid_q && (rsp_owner_q == MST_M0);
    m1_hit    = rsp_valid_q && (rsp_owner_q == MST_M1);
    M0_RVALID = m0_hit;
    M1_RVALID = m1_hit;
    M0_ERR    = m0_hit && rsp_err_q;
    M1_ERR    = m1_hit && rsp_err_q;
    M0_RDATA  = (m0_hit && rsp_rd_q) ? MEM_DOUT : '0;
    M1_RDATA  = (m1_hit && rsp_rd_q) ? MEM_DOUT : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (DATA_MEM, 1024 x 32-bit words) between two requesters:
  - M0: the RISC_V core data port.
  - M1: an external loader/debug master.
- Arbitrates round-robin with optional M1 bus lock.
- Translates byte addresses to word indices (ADDR - BASE_ADDR) / 4 and range-checks them.
- Returns read data with a valid/error tag to the granted master one cycle after issue.
- Sits between the core and DATA_MEM in the top-level and the bench.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte-address width on master ports.
- BASE_ADDR, 8192, byte address of memory word 0.
- NEL, 1024, number of memory words.
- IDX_W, 10, word-index width (clog2(NEL)).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- M0_REQ  in  1  core request.
- M0_WE  in  1  1 = write, 0 = read.
- M0_ADDR  in  ADDR_W  core byte address.
- M0_WDATA  in  DATA_W  core write data.
- M0_GNT  out  1  request accepted this cycle (combinational).
- M0_RVALID  out  1  response valid.
- M0_RDATA  out  DATA_W  read data.
- M0_ERR  out  1  response is an address error.
- M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_GNT, M1_RVALID, M1_RDATA, M1_ERR: same as M0, for M1.
- M1_LOCK  in  1  while high with M1 granted, M1 keeps priority.
- MEM_ADDR  out  IDX_W  word index to DATA_MEM.
- MEM_WR_EN  out  1  memory write strobe.
- MEM_RD_EN  out  1  memory read strobe.
- MEM_DIN  out  DATA_W  write data to memory.
- MEM_DOUT  in  DATA_W  memory read data, valid cycle after MEM_RD_EN.

Behaviour:
- Reset (RST=1 at an edge):
  - LAST_GNT<=M1, so M0 wins the first tie.
  - LOCKED<=0; all response registers cleared.
  - M*_RVALID, M*_ERR and M*_RDATA read 0 the cycle after reset.
  - GNT/MEM strobes are forced 0 while RST=1.
- Handshake:
  - A master holds REQ/WE/ADDR/WDATA stable until it sees GNT=1 in the same cycle; the transfer completes on that edge.
  - At most one grant per cycle. Back-to-back grants every cycle are allowed.
- Arbitration (combinational from registered state):
  - Only one REQ: grant it.
  - Both REQ: if LOCKED grant M1, else grant the master not equal to LAST_GNT.
  - LAST_GNT updates on every grant.
  - LOCKED<=1 when M1 is granted with M1_LOCK=1; LOCKED<=0 when M1_LOCK=0.
  - While LOCKED, M0 waits; no starvation guarantee applies during lock.
- Address check:
  - Valid when ADDR >= BASE_ADDR, ADDR < BASE_ADDR + 4*NEL, and ADDR[1:0] == 0.
  - Computed in ADDR_W-bit unsigned arithmetic; values below BASE_ADDR must not wrap into range.
- Valid granted access:
  - MEM_ADDR = (ADDR - BASE_ADDR) >> 2.
  - MEM_WR_EN = WE; MEM_RD_EN = ~WE; MEM_DIN = WDATA; all in the grant cycle.
- Invalid granted access:
  - No memory strobe; GNT still asserted.
  - The next cycle returns RVALID=1, ERR=1, RDATA=0.
- Response pipeline (one register stage, RSP_OWNER, RSP_VALID, RSP_RD, RSP_ERR):
  - The cycle after any grant, RVALID=1 on the owner only.
  - Reads: RDATA = MEM_DOUT.
  - Writes: RVALID=1 and RDATA=0 as the write acknowledge.
  - Latency is one cycle, fixed.
- Idle: MEM_ADDR holds its last value; strobes are 0.
- Simultaneous grant and response: the new grant and the previous response coexist, even across different masters.
- Reset mid-transaction: an in-flight response is dropped (RVALID=0) and a pending lock is cleared.

Decomposition:
- Package dmem_pkg:
  - DATA_W, ADDR_W, BASE_ADDR, NEL, IDX_W.
  - Master-ID encoding (M0=0, M1=1).
  - Function addr_in_range.
- Sub-module rr_arb2: two-input round-robin with lock. Contains LAST_GNT and LOCKED; outputs one-hot grant.
- The top holds address translation and the response register.

Test Plan:
- Reset then M0 read at 0x2004 with MEM word1=0xDEADBEEF -> M0_GNT same cycle, MEM_ADDR=1, MEM_RD_EN=1; next cycle M0_RVALID=1, M0_RDATA=0xDEADBEEF, M0_ERR=0.
- M0 and M1 request together for 4 cycles -> grants alternate M0, M1, M0, M1; each RVALID appears one cycle later on the matching master only.
- M1 writes 0x12345678 to 0x2FFC with M1_LOCK=1 while M0 requests -> MEM_ADDR=1023, MEM_WR_EN=1; M0 blocked until M1_LOCK falls; then M0 granted next cycle.
- M0 read at 0x1FFC, 0x3000, 0x2002 -> GNT=1 each; no MEM strobe; RVALID=1, ERR=1, RDATA=0 each.
- RST asserted the cycle after an M0 read grant -> no RVALID the following cycle; after release, M0 wins a tie with M1.
- Back-to-back M0 write to 0x2010 of 0xA5A5A5A5 then read of 0x2010 -> write ack RVALID, then read RDATA=0xA5A5A5A5.
